mha_score_engine: RTL

MHA_SCORE_ENGINE -- requirements
Module: mha_score_engine

---
 rtl/mha_score_engine.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mha_score_engine.sv
// Multi-head attention score engine: per-head q.k dot product, scaled by 1/sqrt(HEAD_DIM), saturated.
// Define MHA_SCORE_MASK_EN to force masked heads (mask bit set on the final beat) to the most negative score.
module mha_score_engine #(
    parameter int NUM_HEADS = 8,
    parameter int HEAD_DIM  = 64,
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_HEADS*WIDTH-1:0]     q_data,
    input  logic [NUM_HEADS*WIDTH-1:0]     k_data,
    input  logic                           in_last,
    input  logic [NUM_HEADS-1:0]           mask,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_HEADS*OUT_WIDTH-1:0] out_score,
    output logic                           err
);
    localparam int LOG2_DIM = $clog2(HEAD_DIM);
    localparam int SHIFT    = LOG2_DIM / 2;
    localparam int ACC_W    = 2*WIDTH + LOG2_DIM;
    localparam int PROD_W   = 2*WIDTH;
    localparam int CNT_W    = (LOG2_DIM > 0) ? LOG2_DIM : 1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(HEAD_DIM - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, SCALE, OUT} state_t;

    state_t                         state;
    logic [CNT_W-1:0]               cnt;
    logic signed [ACC_W-1:0]        acc   [NUM_HEADS];
    logic signed [PROD_W-1:0]       prod  [NUM_HEADS];
    logic signed [ACC_W-1:0]        sum   [NUM_HEADS];
    logic signed [ACC_W-1:0]        shifted;
    logic [OUT_WIDTH-1:0]           sat;
    logic [NUM_HEADS*OUT_WIDTH-1:0] score_next;
    logic                           accept;
    logic                           final_beat;

`ifdef MHA_SCORE_MASK_EN
    logic [NUM_HEADS-1:0] mask_q;
`else
    logic unused_mask;
    assign unused_mask = ^mask;
`endif

    // Gated by rst_n so the block never advertises readiness while reset is held.
    assign in_ready   = rst_n && (state == IDLE || state == ACC);
    assign accept     = in_valid && in_ready;
    assign final_beat = (cnt == LAST_BEAT);

    always_comb begin
        score_next = '0;
        shifted    = '0;
        sat        = '0;
        for (int unsigned h = 0; h < NUM_HEADS; h++) begin
            prod[h] = PROD_W'($signed(q_data[h*WIDTH +: WIDTH]))
                    * PROD_W'($signed(k_data[h*WIDTH +: WIDTH]));
            // The first accepted beat starts a fresh sum instead of adding to stale contents.
            sum[h]  = ((state == IDLE) ? '0 : acc[h]) + ACC_W'(prod[h]);
            shifted = acc[h] >>> SHIFT;
            if (shifted > SAT_MAX) begin
                sat = SAT_MAX[OUT_WIDTH-1:0];
            end else if (shifted < SAT_MIN) begin
                sat = SAT_MIN[OUT_WIDTH-1:0];
            end else begin
                sat = shifted[OUT_WIDTH-1:0];
            end
`ifdef MHA_SCORE_MASK_EN
            if (mask_q[h]) begin
                sat = SAT_MIN[OUT_WIDTH-1:0];
            end
`endif
            score_next[h*OUT_WIDTH +: OUT_WIDTH] = sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_score <= '0;
            err       <= 1'b0;
            for (int unsigned h = 0; h < NUM_HEADS; h++) begin
                acc[h] <= '0;
            end
`ifdef MHA_SCORE_MASK_EN
            mask_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        for (int unsigned h = 0; h < NUM_HEADS; h++) begin
                            acc[h] <= sum[h];
                        end
                        if (final_beat) begin
                            cnt   <= '0;
                            state <= SCALE;
                            if (!in_last) err <= 1'b1;
`ifdef MHA_SCORE_MASK_EN
                            mask_q <= mask;
`endif
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= ACC;
                            if (in_last) err <= 1'b1;
                        end
                    end
                end
                SCALE: begin
                    out_score <= score_next;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
